// File: rtl/ae_rate_ctrl.sv
// ae_rate_ctrl
// Sequencer for the acquisition-engine rate adaptor. The host fills a small
// per-channel configuration table. On start the block walks the table from
// first_ch to last_ch, wrapping from the top entry back to entry 0. For each
// channel it:
//   - loads ratio, frequency and threshold into the adaptor,
//   - pulses init_nco,
//   - discards FLUSH_CNT outputs while the filter taps refill,
//   - then passes samples until len requantized outputs have been collected.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_*               table write port (cfg_we, cfg_addr, ratio/freq/thresh/len)
//   start, abort        sequence control pulses
//   first_ch, last_ch   channel range, sampled at start
//   sample_valid_i/o    raw and gated sample strobe
//   data_valid_i        requantized output strobe from the adaptor
//   data_en             qualified output strobe for the sample buffer
//   init_nco            NCO clear pulse
//   code_rate_ratio,
//   carrier_freq,
//   threshold           adaptor configuration, registered at LOAD
//   busy                sequence in progress
//   ch_index            active entry
//   ch_done, all_done   completion pulses
//   out_count           outputs counted for the current channel
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// LOAD  | register table entry into adaptor outputs, clear out_count
// INIT  | init_nco high, samples blocked
// FLUSH | samples pass, stale filter outputs discarded
// RUN   | samples pass, outputs enabled and counted up to len
// NEXT  | ch_done; advance to next channel or finish with all_done
module ae_rate_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int FLUSH_CNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [23:0]       cfg_ratio,
  input  logic [31:0]       cfg_freq,
  input  logic [7:0]        cfg_thresh,
  input  logic [15:0]       cfg_len,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_ch,
  input  logic [ADDR_W-1:0] last_ch,
  input  logic              sample_valid_i,
  output logic              sample_valid_o,
  input  logic              data_valid_i,
  output logic              data_en,
  output logic              init_nco,
  output logic [23:0]       code_rate_ratio,
  output logic [31:0]       carrier_freq,
  output logic [7:0]        threshold,
  output logic              busy,
  output logic [ADDR_W-1:0] ch_index,
  output logic              ch_done,
  output logic              all_done,
  output logic [15:0]       out_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int FW    = (FLUSH_CNT > 1) ? $clog2(FLUSH_CNT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INIT, S_FLUSH, S_RUN, S_NEXT
  } state_t;

  state_t state;

  logic [23:0] tbl_ratio  [DEPTH];
  logic [31:0] tbl_freq   [DEPTH];
  logic [7:0]  tbl_thresh [DEPTH];
  logic [15:0] tbl_len    [DEPTH];

  logic [ADDR_W-1:0] last_r;
  logic [15:0]       len_r;
  logic [FW-1:0]     flush_left;

  // The table is storage, not control state, so reset leaves it intact.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      tbl_ratio[cfg_addr]  <= cfg_ratio;
      tbl_freq[cfg_addr]   <= cfg_freq;
      tbl_thresh[cfg_addr] <= cfg_thresh;
      tbl_len[cfg_addr]    <= cfg_len;
    end
  end

  assign sample_valid_o = ((state == S_FLUSH) || (state == S_RUN)) && sample_valid_i;
  // out_count only equals len_r in RUN when len is 0; nothing is enabled then.
  assign data_en = (state == S_RUN) && data_valid_i && (out_count != len_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      init_nco        <= 1'b0;
      ch_done         <= 1'b0;
      all_done        <= 1'b0;
      ch_index        <= '0;
      last_r          <= '0;
      out_count       <= '0;
      len_r           <= '0;
      flush_left      <= '0;
      code_rate_ratio <= '0;
      carrier_freq    <= '0;
      threshold       <= '0;
    end else begin
      init_nco <= 1'b0;
      ch_done  <= 1'b0;
      all_done <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_LOAD;
              ch_index <= first_ch;
              last_r   <= last_ch;
              busy     <= 1'b1;
            end
          end
          S_LOAD: begin
            code_rate_ratio <= tbl_ratio[ch_index];
            carrier_freq    <= tbl_freq[ch_index];
            threshold       <= tbl_thresh[ch_index];
            len_r           <= tbl_len[ch_index];
            out_count       <= '0;
            init_nco        <= 1'b1;
            state           <= S_INIT;
          end
          S_INIT: begin
            flush_left <= FW'(FLUSH_CNT);
            state      <= (FLUSH_CNT == 0) ? S_RUN : S_FLUSH;
          end
          S_FLUSH: begin
            if (data_valid_i) begin
              if (flush_left == FW'(1)) state <= S_RUN;
              else flush_left <= flush_left - 1'b1;
            end
          end
          S_RUN: begin
            if (out_count == len_r) begin
              state    <= S_NEXT;
              ch_done  <= 1'b1;
              all_done <= (ch_index == last_r);
            end else if (data_valid_i) begin
              out_count <= out_count + 16'd1;
              if (out_count + 16'd1 == len_r) begin
                state    <= S_NEXT;
                ch_done  <= 1'b1;
                all_done <= (ch_index == last_r);
              end
            end
          end
          S_NEXT: begin
            if (ch_index == last_r) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              ch_index <= ch_index + 1'b1;
              state    <= S_LOAD;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ae_rate_ctrl.sv
// Directed bench for ae_rate_ctrl: single channel, wrapped range, gating,
// abort, start-while-busy, live table write, len 0 and mid-sequence reset.
module tb_ae_rate_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [23:0] cfg_ratio;
  logic [31:0] cfg_freq;
  logic [7:0]  cfg_thresh;
  logic [15:0] cfg_len;
  logic        start, abort;
  logic [2:0]  first_ch, last_ch;
  logic        sample_valid_i, sample_valid_o;
  logic        data_valid_i, data_en, init_nco;
  logic [23:0] code_rate_ratio;
  logic [31:0] carrier_freq;
  logic [7:0]  threshold;
  logic        busy, ch_done, all_done;
  logic [2:0]  ch_index;
  logic [15:0] out_count;

  int total = 0;
  int bad   = 0;
  int n_init = 0, n_chd = 0, n_alld = 0, n_den = 0;

  always #5 clk = ~clk;

  ae_rate_ctrl #(.ADDR_W(3), .FLUSH_CNT(3)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_ratio(cfg_ratio),
    .cfg_freq(cfg_freq), .cfg_thresh(cfg_thresh), .cfg_len(cfg_len),
    .start(start), .abort(abort), .first_ch(first_ch), .last_ch(last_ch),
    .sample_valid_i(sample_valid_i), .sample_valid_o(sample_valid_o),
    .data_valid_i(data_valid_i), .data_en(data_en), .init_nco(init_nco),
    .code_rate_ratio(code_rate_ratio), .carrier_freq(carrier_freq),
    .threshold(threshold), .busy(busy), .ch_index(ch_index),
    .ch_done(ch_done), .all_done(all_done), .out_count(out_count)
  );

  always @(negedge clk) begin
    if (init_nco) n_init++;
    if (ch_done)  n_chd++;
    if (all_done) n_alld++;
    if (data_en)  n_den++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [23:0] r, input logic [31:0] f,
                    input logic [7:0] t, input logic [15:0] l);
    cfg_we = 1'b1; cfg_addr = a; cfg_ratio = r; cfg_freq = f; cfg_thresh = t; cfg_len = l;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_ch(input logic [2:0] f, input logic [2:0] l);
    first_ch = f; last_ch = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Three data_valid_i pulses move FLUSH to RUN.
  task automatic flush3();
    data_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    data_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_chd, s_alld, s_init, s_den, ncap;
    logic [2:0] seq [4];
    logic done;

    rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_ratio = 0; cfg_freq = 0; cfg_thresh = 0;
    cfg_len = 0; start = 0; abort = 0; first_ch = 0; last_ch = 0;
    sample_valid_i = 1'b1; data_valid_i = 0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ratio", code_rate_ratio, 0);
    chk("rst_chidx", ch_index, 0);
    chk("rst_svo", sample_valid_o, 0);
    rst = 1'b0;

    wr(3'd2, 24'h400000, 32'h10000000, 8'd12, 16'd4);
    wr(3'd3, 24'h000111, 32'h00000222, 8'd33, 16'd3);
    wr(3'd4, 24'h000444, 32'h00000555, 8'd44, 16'd2);
    wr(3'd5, 24'h000005, 32'h00000005, 8'd20, 16'd3);
    wr(3'd6, 24'h000006, 32'h00000060, 8'd6, 16'd2);
    wr(3'd7, 24'h000007, 32'h00000070, 8'd7, 16'd2);
    wr(3'd0, 24'h000010, 32'h00000100, 8'd1, 16'd2);
    wr(3'd1, 24'h000011, 32'h00000110, 8'd2, 16'd2);

    // single channel, entry 2
    start_ch(3'd2, 3'd2);
    chk("s1_busy", busy, 1);
    chk("s1_init_load", init_nco, 0);
    chk("s1_svo_load", sample_valid_o, 0);
    tick();
    chk("s1_init", init_nco, 1);
    chk("s1_ratio", code_rate_ratio, 32'h400000);
    chk("s1_freq", carrier_freq, 32'h10000000);
    chk("s1_thresh", threshold, 12);
    chk("s1_chidx", ch_index, 2);
    chk("s1_svo_init", sample_valid_o, 0);
    tick();
    chk("s1_svo_flush", sample_valid_o, 1);
    for (int i = 0; i < 7; i++) begin
      data_valid_i = 1'b1; #1;
      chk("s1_den", data_en, (i >= 3) ? 1 : 0);
      tick();
    end
    data_valid_i = 1'b0;
    chk("s1_chdone", ch_done, 1);
    chk("s1_alldone", all_done, 1);
    chk("s1_cnt", out_count, 4);
    chk("s1_busy_next", busy, 1);
    tick();
    chk("s1_busy_fall", busy, 0);
    chk("s1_chdone_off", ch_done, 0);

    // gating with continuous strobes, entry 3 len 3
    start_ch(3'd3, 3'd3);
    chk("g_svo_load", sample_valid_o, 0);
    tick();
    chk("g_svo_init", sample_valid_o, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      data_valid_i = 1'b1; #1;
      chk("g_svo_pass", sample_valid_o, 1);
      chk("g_den", data_en, (i >= 3) ? 1 : 0);
      tick();
    end
    chk("g_next_done", ch_done, 1);
    chk("g_svo_next", sample_valid_o, 0);
    chk("g_den_next", data_en, 0);
    tick();
    chk("g_svo_idle", sample_valid_o, 0);
    chk("g_den_resid", data_en, 0);
    data_valid_i = 1'b0;

    // wrapped range 6..1
    s_chd = n_chd; s_alld = n_alld; s_init = n_init; s_den = n_den;
    ncap = 0; done = 1'b0;
    data_valid_i = 1'b1;
    start_ch(3'd6, 3'd1);
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      if (init_nco) begin
        if (ncap < 4) seq[ncap] = ch_index;
        ncap++;
      end
      if (all_done) done = 1'b1;
    end
    data_valid_i = 1'b0;
    tick();
    chk("w_finished", done, 1);
    chk("w_ninit_seen", ncap, 4);
    chk("w_seq0", seq[0], 6);
    chk("w_seq1", seq[1], 7);
    chk("w_seq2", seq[2], 0);
    chk("w_seq3", seq[3], 1);
    chk("w_chdone", n_chd - s_chd, 4);
    chk("w_alldone", n_alld - s_alld, 1);
    chk("w_init", n_init - s_init, 4);
    chk("w_den", n_den - s_den, 8);
    chk("w_busy", busy, 0);

    // abort in RUN at out_count 1, coinciding with the completing output
    start_ch(3'd4, 3'd4);
    tick(); tick();
    flush3();
    data_valid_i = 1'b1; tick();
    chk("a_cnt1", out_count, 1);
    s_chd = n_chd; s_alld = n_alld;
    abort = 1'b1;
    tick();
    abort = 1'b0; data_valid_i = 1'b0;
    chk("a_busy", busy, 0);
    chk("a_chdone", ch_done, 0);
    tick();
    chk("a_no_chdone", n_chd - s_chd, 0);
    chk("a_no_alldone", n_alld - s_alld, 0);
    chk("a_svo_idle", sample_valid_o, 0);
    start_ch(3'd4, 3'd4);
    chk("a_restart_busy", busy, 1);
    tick();
    chk("a_restart_init", init_nco, 1);
    chk("a_restart_ch", ch_index, 4);
    chk("a_restart_cnt", out_count, 0);
    tick();
    first_ch = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("sb_chidx", ch_index, 4);
    tick();
    chk("sb_no_init", init_nco, 0);
    chk("sb_svo_flush", sample_valid_o, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("sb_abort_busy", busy, 0);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("sa_idle", busy, 0);

    // table write to the active entry while running
    start_ch(3'd5, 3'd5);
    tick();
    chk("cw_thresh0", threshold, 20);
    tick();
    flush3();
    data_valid_i = 1'b1; tick(); data_valid_i = 1'b0;
    wr(3'd5, 24'h000005, 32'h00000005, 8'd99, 16'd3);
    chk("cw_hold", threshold, 20);
    data_valid_i = 1'b1; tick(); tick(); data_valid_i = 1'b0;
    chk("cw_done", ch_done, 1);
    tick();
    start_ch(3'd5, 3'd5);
    tick();
    chk("cw_reload", threshold, 99);
    abort = 1'b1; tick(); abort = 1'b0;

    // len 0
    wr(3'd0, 24'h000010, 32'h00000100, 8'd1, 16'd0);
    s_den = n_den;
    start_ch(3'd0, 3'd0);
    tick(); tick();
    flush3();
    data_valid_i = 1'b1; #1;
    chk("z_den", data_en, 0);
    tick();
    data_valid_i = 1'b0;
    chk("z_chdone", ch_done, 1);
    chk("z_alldone", all_done, 1);
    chk("z_cnt", out_count, 0);
    tick();
    chk("z_den_total", n_den - s_den, 0);

    // reset in FLUSH
    start_ch(3'd2, 3'd2);
    tick(); tick();
    chk("r_pre_svo", sample_valid_o, 1);
    rst = 1'b1; tick();
    chk("r_busy", busy, 0);
    chk("r_ratio", code_rate_ratio, 0);
    chk("r_freq", carrier_freq, 0);
    chk("r_thresh", threshold, 0);
    chk("r_chidx", ch_index, 0);
    chk("r_svo", sample_valid_o, 0);
    rst = 1'b0; tick();
    start_ch(3'd2, 3'd2);
    chk("r_start_busy", busy, 1);
    tick();
    chk("r_start_init", init_nco, 1);
    chk("r_table_kept", code_rate_ratio, 32'h400000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
